// File: rtl/voice_allocator_pkg.sv
// voice_allocator_pkg: shared FSM/candidate enums and the latched note event.
package voice_allocator_pkg;
  localparam int EVT_NOTE_W = 16;
  localparam int EVT_FREQ_W = 32;
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_e;
  typedef enum logic [2:0] {C_NONE, C_MATCH, C_IDLE, C_RELEASED, C_STEAL} cand_e;
  typedef struct packed {
    logic                  on;
    logic [EVT_NOTE_W-1:0] note;
    logic [EVT_FREQ_W-1:0] freq;
  } evt_t;
endpackage

// File: rtl/voice_lru.sv
// voice_lru: per-voice age ranks (0 = newest) kept as a permutation; touch moves a voice to rank 0.
module voice_lru #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            touch_i,
  input  logic [IW-1:0]   touch_idx_i,
  output logic [N*IW-1:0] rank_o,
  output logic [IW-1:0]   oldest_o
);
  logic [IW-1:0] rank_q [N];
  logic [IW-1:0] old;
  assign old = rank_q[touch_idx_i];
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < N; i++) rank_q[i] <= IW'(i);
    end else if (touch_i) begin
      for (int i = 0; i < N; i++)
        rank_q[i] <= (IW'(i) == touch_idx_i) ? '0 : rank_q[i] + IW'(rank_q[i] < old);
    end
  end
  always_comb begin
    oldest_o = '0;
    for (int i = 0; i < N; i++) if (rank_q[i] == IW'(N - 1)) oldest_o = IW'(i);
  end
  for (genvar g = 0; g < N; g++) begin : g_rank
    assign rank_o[g*IW +: IW] = rank_q[g];
  end
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: scans voices one per cycle and commits note-on/off with retrigger/idle/released/steal priority.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = 7,
  parameter int FREQ_W     = 16
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         evt_valid_i,
  output logic                         evt_ready_o,
  input  logic                         evt_on_i,
  input  logic [NOTE_W-1:0]            evt_note_i,
  input  logic [FREQ_W-1:0]            evt_freq_i,
  input  logic [NUM_VOICES-1:0]        voice_busy_i,
  output logic [NUM_VOICES-1:0]        voice_trig_o,
  output logic [NUM_VOICES-1:0]        voice_gate_o,
  output logic [NUM_VOICES*FREQ_W-1:0] voice_freq_o,
  output logic                         steal_o,
  output logic                         miss_o
);
  localparam int IW = $clog2(NUM_VOICES);
  state_e                  state_q;
  evt_t                    ev_q;
  logic [NUM_VOICES-1:0]   busy_q, gate_q, trig_q;
  logic [NOTE_W-1:0]       note_q [NUM_VOICES];
  logic [FREQ_W-1:0]       freq_q [NUM_VOICES];
  logic [IW-1:0]           idx_q, match_q, idle_q, rel_q;
  logic                    match_v_q, idle_v_q, rel_v_q, steal_q, miss_q;
  logic [NUM_VOICES*IW-1:0] rank;
  logic [IW-1:0]           oldest, sel, cur_rank, rel_rank;
  logic                    touch, note_eq;
  cand_e                   cls;
  voice_lru #(.N(NUM_VOICES), .IW(IW)) u_lru (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .touch_i    (touch),
    .touch_idx_i(sel),
    .rank_o     (rank),
    .oldest_o   (oldest)
  );
  assign cur_rank = rank[idx_q*IW +: IW];
  assign rel_rank = rank[rel_q*IW +: IW];
  assign note_eq  = note_q[idx_q] == ev_q.note[NOTE_W-1:0];
  // Steal is only reached when every voice is gated, so the global oldest is the right victim.
  assign cls = !ev_q.on ? (match_v_q ? C_MATCH : C_NONE) :
               match_v_q ? C_MATCH : idle_v_q ? C_IDLE : rel_v_q ? C_RELEASED : C_STEAL;
  assign sel = cls == C_IDLE ? idle_q : cls == C_RELEASED ? rel_q : cls == C_STEAL ? oldest : match_q;
  assign touch = state_q == S_COMMIT && ev_q.on;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      ev_q      <= '0;
      busy_q    <= '0;
      gate_q    <= '0;
      trig_q    <= '0;
      idx_q     <= '0;
      match_q   <= '0;
      idle_q    <= '0;
      rel_q     <= '0;
      match_v_q <= 1'b0;
      idle_v_q  <= 1'b0;
      rel_v_q   <= 1'b0;
      steal_q   <= 1'b0;
      miss_q    <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        freq_q[i] <= '0;
      end
    end else begin
      trig_q  <= '0;
      steal_q <= 1'b0;
      miss_q  <= 1'b0;
      case (state_q)
        S_IDLE: if (evt_valid_i) begin
          ev_q      <= '{on: evt_on_i, note: EVT_NOTE_W'(evt_note_i), freq: EVT_FREQ_W'(evt_freq_i)};
          busy_q    <= voice_busy_i;
          idx_q     <= '0;
          match_v_q <= 1'b0;
          idle_v_q  <= 1'b0;
          rel_v_q   <= 1'b0;
          state_q   <= S_SCAN;
        end
        S_SCAN: begin
          if (gate_q[idx_q] && note_eq && !match_v_q) begin
            match_v_q <= 1'b1;
            match_q   <= idx_q;
          end
          if (!gate_q[idx_q] && !busy_q[idx_q] && !idle_v_q) begin
            idle_v_q <= 1'b1;
            idle_q   <= idx_q;
          end
          if (!gate_q[idx_q] && busy_q[idx_q] && (!rel_v_q || cur_rank > rel_rank)) begin
            rel_v_q <= 1'b1;
            rel_q   <= idx_q;
          end
          idx_q <= idx_q + 1'b1;
          if (int'(idx_q) == NUM_VOICES - 1) state_q <= S_COMMIT;
        end
        S_COMMIT: begin
          state_q <= S_IDLE;
          if (ev_q.on) begin
            note_q[sel] <= ev_q.note[NOTE_W-1:0];
            freq_q[sel] <= ev_q.freq[FREQ_W-1:0];
            gate_q[sel] <= 1'b1;
            trig_q[sel] <= 1'b1;
            steal_q     <= cls == C_STEAL;
          end else if (match_v_q) gate_q[match_q] <= 1'b0;
          else miss_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign evt_ready_o  = state_q == S_IDLE;
  assign voice_trig_o = trig_q;
  assign voice_gate_o = gate_q;
  assign steal_o      = steal_q;
  assign miss_o       = miss_q;
  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_freq
    assign voice_freq_o[g*FREQ_W +: FREQ_W] = freq_q[g];
  end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed + random events against an age-list reference model, compared every cycle.
module tb_voice_allocator;
  localparam int N = 4;
  logic        clk_i = 1'b0, rstn_i = 1'b0;
  logic        evt_valid_i = 1'b0, evt_on_i = 1'b0;
  logic [6:0]  evt_note_i = '0;
  logic [15:0] evt_freq_i = '0;
  logic [3:0]  voice_busy_i = '0;
  logic        evt_ready_o, steal_o, miss_o;
  logic [3:0]  voice_trig_o, voice_gate_o;
  logic [63:0] voice_freq_o;

  voice_allocator #(.NUM_VOICES(N), .NOTE_W(7), .FREQ_W(16)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .evt_valid_i(evt_valid_i), .evt_ready_o(evt_ready_o),
    .evt_on_i(evt_on_i), .evt_note_i(evt_note_i), .evt_freq_i(evt_freq_i),
    .voice_busy_i(voice_busy_i), .voice_trig_o(voice_trig_o), .voice_gate_o(voice_gate_o),
    .voice_freq_o(voice_freq_o), .steal_o(steal_o), .miss_o(miss_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0, n_fail = 0;
  logic        m_ready = 1'b1, m_steal = 1'b0, m_miss = 1'b0;
  logic [3:0]  m_trig = '0, m_gate = '0;
  int          m_note [N];
  logic [15:0] m_freq [N];
  int          order[$];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  function automatic logic [63:0] flat_freq();
    logic [63:0] r = '0;
    for (int v = 0; v < N; v++) r[v*16 +: 16] = m_freq[v];
    return r;
  endfunction

  function automatic logic [7:0] flat_rank();
    logic [7:0] r = '0;
    for (int k = 0; k < N; k++) r[order[k]*2 +: 2] = 2'(k);
    return r;
  endfunction

  function automatic void model_reset();
    m_ready = 1'b1; m_steal = 1'b0; m_miss = 1'b0; m_trig = '0; m_gate = '0;
    order = {};
    for (int v = 0; v < N; v++) begin
      m_note[v] = 0; m_freq[v] = '0; order.push_back(v);
    end
  endfunction

  function automatic void model_commit(bit on, int n, logic [15:0] f, logic [3:0] b);
    int v = -1;
    int pos = 0;
    m_trig = '0; m_steal = 1'b0; m_miss = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < N; i++) if (v < 0 && m_gate[i] && m_note[i] == n) v = i;
    if (!on) begin
      if (v < 0) m_miss = 1'b1;
      else m_gate[v] = 1'b0;
      return;
    end
    for (int i = 0; i < N; i++) if (v < 0 && !m_gate[i] && !b[i]) v = i;
    for (int k = N - 1; k >= 0; k--) if (v < 0 && !m_gate[order[k]] && b[order[k]]) v = order[k];
    if (v < 0) begin
      v = order[N-1]; m_steal = 1'b1;
    end
    m_note[v] = n; m_freq[v] = f; m_gate[v] = 1'b1; m_trig[v] = 1'b1;
    for (int k = 0; k < N; k++) if (order[k] == v) pos = k;
    order.delete(pos);
    order.push_front(v);
  endfunction

  always @(negedge clk_i) if (rstn_i) begin
    chk("ready", 64'(evt_ready_o), 64'(m_ready));
    chk("trig", 64'(voice_trig_o), 64'(m_trig));
    chk("gate", 64'(voice_gate_o), 64'(m_gate));
    chk("freq", voice_freq_o, flat_freq());
    chk("steal", 64'(steal_o), 64'(m_steal));
    chk("miss", 64'(miss_o), 64'(m_miss));
    chk("rank", 64'(dut.u_lru.rank_o), 64'(flat_rank()));
  end

  task automatic wait_ready();
    for (int k = 0; k < 20 && !evt_ready_o; k++) @(negedge clk_i);
    if (!evt_ready_o) chk("ready_timeout", 64'(evt_ready_o), 64'd1);
  endtask

  task automatic send(bit on, logic [6:0] n, logic [15:0] f, logic [3:0] b);
    wait_ready();
    evt_valid_i = 1'b1; evt_on_i = on; evt_note_i = n; evt_freq_i = f; voice_busy_i = b;
    @(posedge clk_i); #1;
    evt_valid_i = 1'b0; evt_on_i = 1'($urandom); evt_note_i = 7'($urandom); evt_freq_i = 16'($urandom);
    m_ready = 1'b0; m_trig = '0; m_steal = 1'b0; m_miss = 1'b0;
    for (int k = 0; k <= N; k++) begin
      voice_busy_i = 4'($urandom);
      @(posedge clk_i); #1;
    end
    model_commit(on, int'(n), f, b);
    @(negedge clk_i);
  endtask

  task automatic gap();
    @(posedge clk_i); #1;
    m_trig = '0; m_steal = 1'b0; m_miss = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();
    chk("rst_ready", 64'(evt_ready_o), 64'd1);
    chk("rst_gate", 64'(voice_gate_o), 64'd0);
    chk("rst_freq", voice_freq_o, 64'd0);
    chk("rst_rank", 64'(dut.u_lru.rank_o), 64'he4);

    send(1'b1, 7'd60, 16'h0100, 4'b0000);
    chk("on60_trig", 64'(voice_trig_o), 64'b0001);
    chk("on60_gate", 64'(voice_gate_o), 64'b0001);
    chk("on60_freq0", 64'(voice_freq_o[15:0]), 64'h0100);
    chk("on60_ready", 64'(evt_ready_o), 64'd1);
    send(1'b1, 7'd62, 16'h0200, 4'b0001);
    send(1'b1, 7'd64, 16'h0300, 4'b0011);
    send(1'b1, 7'd65, 16'h0400, 4'b0111);
    chk("fill_trig3", 64'(voice_trig_o), 64'b1000);
    send(1'b1, 7'd67, 16'h0500, 4'b1111);
    chk("steal_flag", 64'(steal_o), 64'd1);
    chk("steal_trig", 64'(voice_trig_o), 64'b0001);
    chk("steal_freq0", 64'(voice_freq_o[15:0]), 64'h0500);
    gap();
    chk("steal_pulse_end", 64'(steal_o), 64'd0);
    send(1'b1, 7'd64, 16'h0600, 4'b0000);
    chk("retrig_trig", 64'(voice_trig_o), 64'b0100);
    chk("retrig_nosteal", 64'(steal_o), 64'd0);
    chk("retrig_rank2", 64'(dut.u_lru.rank_o[5:4]), 64'd0);
    send(1'b0, 7'd62, 16'h0000, 4'b0000);
    chk("off62_gate", 64'(voice_gate_o), 64'b1101);
    chk("off62_trig", 64'(voice_trig_o), 64'd0);
    send(1'b0, 7'd70, 16'h0000, 4'b0000);
    chk("off70_miss", 64'(miss_o), 64'd1);
    chk("off70_gate", 64'(voice_gate_o), 64'b1101);

    do_reset();
    send(1'b1, 7'd50, 16'h1111, 4'b1010);
    chk("idle_pick_v0", 64'(voice_trig_o), 64'b0001);
    do_reset();
    send(1'b1, 7'd51, 16'h2222, 4'b1111);
    chk("rel_pick_v3", 64'(voice_trig_o), 64'b1000);
    chk("rel_nosteal", 64'(steal_o), 64'd0);

    send(1'b1, 7'd52, 16'h3333, 4'b0000);
    wait_ready();
    evt_valid_i = 1'b1; evt_on_i = 1'b1; evt_note_i = 7'd53; evt_freq_i = 16'h4444;
    @(posedge clk_i); #1;
    evt_valid_i = 1'b0; m_ready = 1'b0; m_trig = '0;
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b0;
    model_reset();
    #1;
    chk("midrst_ready", 64'(evt_ready_o), 64'd1);
    chk("midrst_gate", 64'(voice_gate_o), 64'd0);
    chk("midrst_trig", 64'(voice_trig_o), 64'd0);
    chk("midrst_freq", voice_freq_o, 64'd0);
    chk("midrst_rank", 64'(dut.u_lru.rank_o), 64'he4);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);

    for (int e = 0; e < 400; e++) begin
      send($urandom_range(0, 2) != 0, 7'(60 + $urandom_range(0, 7)), 16'($urandom), 4'($urandom));
      repeat ($urandom_range(0, 2)) gap();
    end
    gap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
